// File: rtl/delayed_data_memory.sv
// Data-memory responder with a fixed multi-cycle access latency.
// One load or store in flight at a time; loads return data with a register tag.
module delayed_data_memory #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6,
  parameter int LATENCY    = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0] WD,
  input  logic [4:0]       TagIn,
  output logic             Busy,
  output logic             Done,
  output logic             RDValid,
  output logic [WIDTH-1:0] RD,
  output logic [4:0]       TagOut
);

  generate
    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
      $error("delayed_data_memory: LATENCY must be in 2..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } state_e;

  localparam int DEPTH = 2 ** DEPTH_BITS;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  store_q, store_d;
  logic [DEPTH_BITS-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [4:0]            tag_q, tag_d;
  logic                  done_q, done_d;
  logic                  rdvalid_q, rdvalid_d;
  logic [WIDTH-1:0]      rd_q, rd_d;
  logic [4:0]            tagout_q, tagout_d;
  logic                  mem_we;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr[WIDTH-1:DEPTH_BITS+2], Addr[1:0]};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    idx_d     = idx_q;
    data_d    = data_q;
    tag_d     = tag_q;
    done_d    = 1'b0;
    rdvalid_d = 1'b0;
    rd_d      = rd_q;
    tagout_d  = tagout_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemReadM || MemWriteM) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
          store_d = MemWriteM;  // write wins when both are requested
          idx_d   = Addr[DEPTH_BITS+1:2];
          data_d  = WD;
          tag_d   = TagIn;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          if (store_q) begin
            mem_we = 1'b1;
          end else begin
            rd_d      = mem_q[idx_q];
            tagout_d  = tag_q;
            rdvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      store_q   <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      done_q    <= 1'b0;
      rdvalid_q <= 1'b0;
      rd_q      <= '0;
      tagout_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      done_q    <= done_d;
      rdvalid_q <= rdvalid_d;
      rd_q      <= rd_d;
      tagout_q  <= tagout_d;
    end
  end

  // NOTE: the array has no reset; a reset aborts a store because state_q is
  // forced to IDLE, so mem_we cannot assert on the aborted completion edge.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign Busy    = (state_q == WAIT);
  assign Done    = done_q;
  assign RDValid = rdvalid_q;
  assign RD      = rd_q;
  assign TagOut  = tagout_q;

endmodule

// File: tb/tb_delayed_data_memory.sv
// Self-checking bench: LATENCY=3 instance checked every cycle against a
// scoreboard and memory model; a LATENCY=2 instance checks wrap and latency.
module tb_delayed_data_memory;

  localparam int L = 3;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] Addr = '0, WD = '0;
  logic [4:0]  TagIn = '0;
  logic        Busy, Done, RDValid;
  logic [31:0] RD;
  logic [4:0]  TagOut;

  logic        r2 = 1'b0, w2 = 1'b0;
  logic [31:0] a2 = '0, d2 = '0;
  logic [4:0]  t2 = '0;
  logic        busy2, done2, rdvalid2;
  logic [31:0] rd2;
  logic [4:0]  tagout2;

  always #5 CLK = ~CLK;

  delayed_data_memory #(.WIDTH(32), .DEPTH_BITS(6), .LATENCY(L)) dut (
    .CLK(CLK), .CLR(CLR), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Addr(Addr), .WD(WD), .TagIn(TagIn), .Busy(Busy), .Done(Done),
    .RDValid(RDValid), .RD(RD), .TagOut(TagOut)
  );

  delayed_data_memory #(.WIDTH(32), .DEPTH_BITS(6), .LATENCY(2)) dut2 (
    .CLK(CLK), .CLR(CLR), .MemReadM(r2), .MemWriteM(w2),
    .Addr(a2), .WD(d2), .TagIn(t2), .Busy(busy2), .Done(done2),
    .RDValid(rdvalid2), .RD(rd2), .TagOut(tagout2)
  );

  typedef struct {
    logic        is_load;
    logic [5:0]  idx;
    logic [31:0] data;
    logic [4:0]  tag;
    int          due;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] model [64];
  logic [31:0] last_rd;
  logic [4:0]  last_tag;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare the LATENCY=3 instance's outputs for the current cycle.
  task automatic check_outputs();
    logic exp_busy;
    txn_t t;
    exp_busy = (sb.size() > 0) && (cyc < sb[0].due);
    check("busy", 32'(Busy), 32'(exp_busy));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      t = sb.pop_front();
      check("done", 32'(Done), 32'd1);
      if (t.is_load) begin
        check("rdvalid", 32'(RDValid), 32'd1);
        last_rd  = model[t.idx];
        last_tag = t.tag;
      end else begin
        check("rdvalid_store", 32'(RDValid), 32'd0);
        model[t.idx] = t.data;
      end
    end else begin
      check("done_idle", 32'(Done), 32'd0);
      check("rdvalid_idle", 32'(RDValid), 32'd0);
    end
    check("rd", RD, last_rd);
    check("tagout", 32'(TagOut), 32'(last_tag));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
  endtask

  // Drive an accepted request for one cycle and record its expected completion.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] tg);
    txn_t t;
    t.is_load = rd && !wr;
    t.idx     = a[7:2];
    t.data    = d;
    t.tag     = tg;
    t.due     = cyc + L;
    sb.push_back(t);
    MemReadM = rd; MemWriteM = wr; Addr = a; WD = d; TagIn = tg;
    step();
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $error("FAIL wait_done_timeout observed=%0d expected=0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    last_rd = '0; last_tag = '0;

    // Reset held for two cycles, then idle.
    step(); step();
    CLR = 1'b1;
    repeat (5) step();

    // Store then back-to-back load.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    wait_done();
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd9);
    wait_done();
    check("load_10_rd", RD, 32'hDEADBEEF);
    check("load_10_tag", 32'(TagOut), 32'd9);

    // Request presented while Busy is ignored.
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
    MemWriteM = 1'b1; Addr = 32'h10; WD = 32'h1;
    step();
    MemWriteM = 1'b0;
    wait_done();
    repeat (3) step();
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd4);
    wait_done();
    check("ignored_store_rd", RD, 32'hDEADBEEF);

    // Read and write together act as a store.
    issue(1'b1, 1'b1, 32'h20, 32'h55, 5'd1);
    wait_done();
    issue(1'b1, 1'b0, 32'h20, 32'h0, 5'd2);
    wait_done();
    check("both_high_rd", RD, 32'h55);

    // Asynchronous reset in the middle of a store.
    issue(1'b0, 1'b1, 32'h30, 32'h0, 5'd0);
    wait_done();
    issue(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 5'd0);
    #2 CLR = 1'b0;
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_rd", RD, 32'h0);
    #1 CLR = 1'b1;
    sb.delete();
    last_rd = '0; last_tag = '0;
    repeat (5) step();
    issue(1'b1, 1'b0, 32'h30, 32'h0, 5'd11);
    wait_done();
    check("aborted_store_rd", RD, 32'h0);

    // LATENCY=2 instance: address wrap and two-cycle response.
    r2 = 1'b0; w2 = 1'b1; a2 = 32'h104; d2 = 32'h77;
    step();
    w2 = 1'b0;
    check("l2_busy", 32'(busy2), 32'd1);
    step();
    check("l2_store_done", 32'(done2), 32'd1);
    check("l2_store_rdvalid", 32'(rdvalid2), 32'd0);
    r2 = 1'b1; a2 = 32'h004; t2 = 5'd7;
    step();
    r2 = 1'b0;
    check("l2_rdvalid_early", 32'(rdvalid2), 32'd0);
    step();
    check("l2_rdvalid", 32'(rdvalid2), 32'd1);
    check("l2_rd_wrap", rd2, 32'h77);
    check("l2_tag", 32'(tagout2), 32'd7);
    step();
    check("l2_rdvalid_pulse", 32'(rdvalid2), 32'd0);
    check("l2_rd_hold", rd2, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
